// File: rtl/arbitro_memoria.sv
// arbitro_memoria: round-robin arbiter and bus sequencer sharing one memory
// port between instruction fetch (read-only) and data access (read/write).
module arbitro_memoria #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int WAIT_CYC = 2
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_Fetch_Req,
  input  logic [ADDR_W-1:0] i_Fetch_Dir,
  output logic              o_Fetch_Ack,
  input  logic              i_Dato_Req,
  input  logic              i_Dato_RW,
  input  logic [ADDR_W-1:0] i_Dato_Dir,
  input  logic [DATA_W-1:0] i_Dato_Wr,
  output logic              o_Dato_Ack,
  output logic [DATA_W-1:0] o_Dato_Leido,
  output logic [ADDR_W-1:0] o_Mem_Dir,
  output logic [DATA_W-1:0] o_Mem_Dato,
  output logic              o_Mem_RW,
  output logic              o_Mem_En,
  input  logic [DATA_W-1:0] i_Mem_Dato,
  output logic              o_Ocupado
);

  localparam int EFF_WAIT = (WAIT_CYC < 1) ? 1 : WAIT_CYC;
  localparam int CNT_W    = (EFF_WAIT > 1) ? $clog2(EFF_WAIT) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_lastData;
  logic              r_grantData;
  logic              r_rw;
  logic [ADDR_W-1:0] r_dir;
  logic [DATA_W-1:0] r_dato;
  logic [DATA_W-1:0] r_leido;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_grantData;
  logic              w_anyReq;

  assign o_Mem_Dir    = r_dir;
  assign o_Mem_Dato   = r_dato;
  assign o_Dato_Leido = r_leido;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // On a tie, the requester that was not served last wins.
  always_comb begin
    w_next      = r_state;
    w_anyReq    = i_Fetch_Req || i_Dato_Req;
    w_grantData = i_Dato_Req && (!i_Fetch_Req || !r_lastData);
    o_Mem_En    = 1'b0;
    o_Mem_RW    = 1'b1;
    o_Fetch_Ack = 1'b0;
    o_Dato_Ack  = 1'b0;
    o_Ocupado   = 1'b1;
    case (r_state)
      IDLE: begin
        o_Ocupado = 1'b0;
        if (w_anyReq) w_next = SETUP;
      end
      SETUP: begin
        o_Mem_RW = r_rw;
        w_next   = ACCESS;
      end
      ACCESS: begin
        o_Mem_En = 1'b1;
        o_Mem_RW = r_rw;
        if (r_cnt == '0) w_next = DONE;
      end
      DONE: begin
        o_Mem_RW    = r_rw;
        o_Fetch_Ack = !r_grantData;
        o_Dato_Ack  = r_grantData;
        w_next      = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_lastData  <= 1'b1;
      r_grantData <= 1'b0;
      r_rw        <= 1'b1;
      r_dir       <= '0;
      r_dato      <= '0;
      r_leido     <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_grantData <= w_grantData;
            r_dir       <= w_grantData ? i_Dato_Dir : i_Fetch_Dir;
            r_rw        <= w_grantData ? i_Dato_RW : 1'b1;
            if (w_grantData) r_dato <= i_Dato_Wr;
          end
        end
        SETUP: r_cnt <= CNT_W'(EFF_WAIT - 1);
        ACCESS: begin
          if (r_cnt == '0) begin
            if (r_rw) r_leido <= i_Mem_Dato;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: r_lastData <= r_grantData;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_memoria.sv
// Testbench for arbitro_memoria: directed scenarios plus random traffic from
// two requesters, checked by a transaction-level scoreboard.
module tb_arbitro_memoria;

  localparam int WAIT = 2;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       fetchReq = 1'b0;
  logic [7:0] fetchDir = 8'h00;
  logic       fetchAck;
  logic       datoReq = 1'b0;
  logic       datoRw = 1'b1;
  logic [7:0] datoDir = 8'h00;
  logic [7:0] datoWr = 8'h00;
  logic       datoAck;
  logic [7:0] datoLeido;
  logic [7:0] memDir;
  logic [7:0] memDato;
  logic       memRw;
  logic       memEn;
  logic [7:0] memRd;
  logic       ocupado;

  logic       f4Req = 1'b0;
  logic [7:0] f4Dir = 8'h00;
  logic       f4Ack;
  logic       d4Req = 1'b0;
  logic       d4Rw = 1'b1;
  logic [7:0] d4Dir = 8'h00;
  logic [7:0] d4Wr = 8'h00;
  logic       d4Ack;
  logic [7:0] leido4;
  logic [7:0] mDir4;
  logic [7:0] mDato4;
  logic       mRw4;
  logic       mEn4;
  logic [7:0] mRd4 = 8'h77;
  logic       ocup4;

  always #5 clk = ~clk;

  arbitro_memoria #(.ADDR_W(8), .DATA_W(8), .WAIT_CYC(WAIT)) dut (
    .i_Clk(clk), .i_Rst_n(rstN),
    .i_Fetch_Req(fetchReq), .i_Fetch_Dir(fetchDir), .o_Fetch_Ack(fetchAck),
    .i_Dato_Req(datoReq), .i_Dato_RW(datoRw), .i_Dato_Dir(datoDir),
    .i_Dato_Wr(datoWr), .o_Dato_Ack(datoAck), .o_Dato_Leido(datoLeido),
    .o_Mem_Dir(memDir), .o_Mem_Dato(memDato), .o_Mem_RW(memRw),
    .o_Mem_En(memEn), .i_Mem_Dato(memRd), .o_Ocupado(ocupado)
  );

  arbitro_memoria #(.ADDR_W(8), .DATA_W(8), .WAIT_CYC(4)) dut4 (
    .i_Clk(clk), .i_Rst_n(rstN),
    .i_Fetch_Req(f4Req), .i_Fetch_Dir(f4Dir), .o_Fetch_Ack(f4Ack),
    .i_Dato_Req(d4Req), .i_Dato_RW(d4Rw), .i_Dato_Dir(d4Dir),
    .i_Dato_Wr(d4Wr), .o_Dato_Ack(d4Ack), .o_Dato_Leido(leido4),
    .o_Mem_Dir(mDir4), .o_Mem_Dato(mDato4), .o_Mem_RW(mRw4),
    .o_Mem_En(mEn4), .i_Mem_Dato(mRd4), .o_Ocupado(ocup4)
  );

  typedef struct {
    bit         isData;
    logic [7:0] dir;
    bit         rw;
    logic [7:0] wdata;
    logic [7:0] expRead;
    int         grantCyc;
    int         ackCycle;
  } txn_t;

  txn_t       sbQ[$];
  txn_t       modelT;
  txn_t       monT;
  logic [7:0] devMem [256];
  logic [7:0] refMem [256];
  logic [7:0] leidoExp = 8'h00;
  bit         lastData = 1'b1;
  int         freeAt = 0;
  int         cyc = 0;
  int         checks = 0;
  int         passes = 0;

  assign memRd = devMem[memDir];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
  endtask

  task automatic flagFail(input string name);
    checks++;
    $display("[TB] FAIL %s: got no response, expected one within bound (cycle %0d)", name, cyc);
  endtask

  // Memory device: initial contents are address ^ 0x66; writes land mid-cycle.
  initial begin
    for (int i = 0; i < 256; i++) devMem[i] = 8'(i) ^ 8'h66;
    forever begin
      @(negedge clk);
      if (memEn && !memRw) devMem[memDir] = memDato;
    end
  end

  // Reference model: one transaction at a time, round robin on ties, each
  // transaction occupying WAIT+3 cycles with its ack in the last of them.
  initial begin
    for (int i = 0; i < 256; i++) refMem[i] = 8'(i) ^ 8'h66;
    forever begin
      @(posedge clk);
      if (!rstN) begin
        sbQ.delete();
        lastData = 1'b1;
        leidoExp = 8'h00;
        freeAt   = 0;
      end else if (cyc >= freeAt && (fetchReq || datoReq)) begin
        modelT.isData = datoReq && (!fetchReq || !lastData);
        if (modelT.isData) begin
          modelT.dir   = datoDir;
          modelT.rw    = datoRw;
          modelT.wdata = datoWr;
        end else begin
          modelT.dir   = fetchDir;
          modelT.rw    = 1'b1;
          modelT.wdata = 8'h00;
        end
        if (modelT.rw) leidoExp = refMem[modelT.dir];
        else           refMem[modelT.dir] = modelT.wdata;
        modelT.expRead  = leidoExp;
        modelT.grantCyc = cyc;
        modelT.ackCycle = cyc + WAIT + 2;
        lastData        = modelT.isData;
        freeAt          = cyc + WAIT + 3;
        sbQ.push_back(modelT);
      end
      cyc++;
    end
  end

  // Monitor: checks the bus against the in-flight transaction and pops on ack.
  initial begin
    forever begin
      @(negedge clk);
      if (rstN) begin
        if (sbQ.size() == 0) begin
          checkOutput("idleBusy", 32'(ocupado), 32'(0));
          checkOutput("idleEn", 32'(memEn), 32'(0));
          checkOutput("idleRw", 32'(memRw), 32'(1));
          if (fetchAck || datoAck) flagFail("unexpectedAck");
        end else begin
          monT = sbQ[0];
          checkOutput("busy", 32'(ocupado), 32'(1));
          checkOutput("busDir", 32'(memDir), 32'(monT.dir));
          checkOutput("busRw", 32'(memRw), 32'(monT.rw));
          if (!monT.rw) checkOutput("busDato", 32'(memDato), 32'(monT.wdata));
          checkOutput("memEn", 32'(memEn),
                      32'(cyc >= monT.grantCyc + 2 && cyc <= monT.grantCyc + 1 + WAIT));
          if (fetchAck || datoAck) begin
            checkOutput("ackWho", 32'({datoAck, fetchAck}), monT.isData ? 32'd2 : 32'd1);
            checkOutput("ackCycle", 32'(cyc), 32'(monT.ackCycle));
            checkOutput("leido", 32'(datoLeido), 32'(monT.expRead));
            void'(sbQ.pop_front());
          end else if (cyc >= monT.ackCycle) begin
            flagFail("missingAck");
            void'(sbQ.pop_front());
          end
        end
      end
    end
  end

  task automatic fetchTxn(input logic [7:0] dir, input int gap);
    bit got = 1'b0;
    repeat (gap) @(negedge clk);
    fetchDir = dir;
    fetchReq = 1'b1;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      got = fetchAck;
    end
    if (!got) flagFail("fetchTimeout");
    fetchReq = 1'b0;
  endtask

  task automatic dataTxn(input logic rw, input logic [7:0] dir, input logic [7:0] wr, input int gap);
    bit got = 1'b0;
    repeat (gap) @(negedge clk);
    datoRw  = rw;
    datoDir = dir;
    datoWr  = wr;
    datoReq = 1'b1;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      got = datoAck;
    end
    if (!got) flagFail("dataTimeout");
    datoReq = 1'b0;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    #2 rstN = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rstN = 1'b1;
    @(negedge clk);
  endtask

  task automatic applyStimulus();
    int c0;
    // Reset values while held in reset.
    repeat (3) @(negedge clk);
    checkOutput("rstFetchAck", 32'(fetchAck), 32'(0));
    checkOutput("rstDatoAck", 32'(datoAck), 32'(0));
    checkOutput("rstLeido", 32'(datoLeido), 32'(0));
    checkOutput("rstMemDir", 32'(memDir), 32'(0));
    checkOutput("rstMemDato", 32'(memDato), 32'(0));
    checkOutput("rstMemRw", 32'(memRw), 32'(1));
    checkOutput("rstMemEn", 32'(memEn), 32'(0));
    checkOutput("rstBusy", 32'(ocupado), 32'(0));
    #2 rstN = 1'b1;
    @(negedge clk);

    $display("[TB] fetch read of 0x3A");
    fetchTxn(8'h3A, 0);
    checkOutput("t1Leido", 32'(datoLeido), 32'h5C);

    $display("[TB] data write 0x55 to 0xAA");
    dataTxn(1'b0, 8'hAA, 8'h55, 1);
    checkOutput("t2LeidoKept", 32'(datoLeido), 32'h5C);

    $display("[TB] fetch address changes after grant");
    fork
      fetchTxn(8'h3A, 1);
      begin
        repeat (3) @(negedge clk);
        fetchDir = 8'hFF;
      end
    join

    $display("[TB] both requesters held continuously after reset");
    pulseReset();
    c0 = cyc;
    fork
      begin fetchTxn(8'h10, 0); fetchTxn(8'h10, 0); end
      begin dataTxn(1'b1, 8'h20, 8'h00, 0); dataTxn(1'b1, 8'h20, 8'h00, 0); end
    join
    checkOutput("t3Span", 32'(cyc - c0), 32'(19));

    $display("[TB] reset during a data read");
    fork
      dataTxn(1'b1, 8'h07, 8'h00, 0);
      begin
        repeat (2) @(negedge clk);
        #2 rstN = 1'b0;
        #1;
        checkOutput("t5Leido", 32'(datoLeido), 32'(0));
        checkOutput("t5En", 32'(memEn), 32'(0));
        checkOutput("t5Rw", 32'(memRw), 32'(1));
        checkOutput("t5Dir", 32'(memDir), 32'(0));
        checkOutput("t5Busy", 32'(ocupado), 32'(0));
        checkOutput("t5Ack", 32'({fetchAck, datoAck}), 32'(0));
        repeat (2) @(negedge clk);
        #2 rstN = 1'b1;
      end
    join
    checkOutput("t5LeidoAfter", 32'(datoLeido), 32'h61);

    $display("[TB] WAIT_CYC=4 fetch");
    @(negedge clk);
    f4Dir = 8'h3A;
    f4Req = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checkOutput("t6En", 32'(mEn4), 32'(k >= 2 && k <= 5));
      checkOutput("t6Ack", 32'(f4Ack), 32'(k == 6));
      checkOutput("t6Busy", 32'(ocup4), 32'(k >= 1 && k <= 6));
      checkOutput("t6Dir", 32'(mDir4), 32'h3A);
      checkOutput("t6Rw", 32'(mRw4), 32'(1));
      checkOutput("t6Dato", 32'(mDato4), 32'(0));
      checkOutput("t6DataAck", 32'(d4Ack), 32'(0));
      if (f4Ack) begin
        checkOutput("t6Leido", 32'(leido4), 32'h77);
        f4Req = 1'b0;
      end
    end
    f4Req = 1'b0;

    $display("[TB] random traffic");
    fork
      begin
        for (int n = 0; n < 30; n++)
          fetchTxn(8'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
      end
      begin
        for (int n = 0; n < 30; n++)
          dataTxn(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
                  8'($urandom), int'($urandom_range(0, 3)));
      end
    join
    repeat (10) @(negedge clk);
    if (sbQ.size() != 0) flagFail("drain");
  endtask

  initial begin
    applyStimulus();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/arbitro_memoria.md
Name: arbitro_memoria

Overview:
- Sequencer and arbiter for the processor's 8-bit memory bus, sitting between the core and the addressing/memory datapath.
- Shares one memory port between two requesters: instruction fetch (read-only) and data access (read/write).
- Grants one transaction at a time with round-robin priority and drives address, write data, R/W and enable through a fixed setup/access/done sequence.
- Returns read data with a one-cycle acknowledge to the granted requester.

Parameters:
ADDR_W, 8, memory address width
DATA_W, 8, memory data width
WAIT_CYC, 2, cycles o_Mem_En is held per access; values below 1 are treated as 1

Ports:
i_Clk  input  1  system clock, rising edge
i_Rst_n  input  1  asynchronous reset, active-low
i_Fetch_Req  input  1  fetch request (read), level, held until ack
i_Fetch_Dir  input  ADDR_W  fetch address
o_Fetch_Ack  output  1  one-cycle pulse: fetch transaction complete
i_Dato_Req  input  1  data request, level, held until ack
i_Dato_RW  input  1  1 = read, 0 = write
i_Dato_Dir  input  ADDR_W  data address
i_Dato_Wr  input  DATA_W  write data
o_Dato_Ack  output  1  one-cycle pulse: data transaction complete
o_Dato_Leido  output  DATA_W  read data; valid with either ack on reads
o_Mem_Dir  output  ADDR_W  memory address
o_Mem_Dato  output  DATA_W  memory write data
o_Mem_RW  output  1  1 = read, 0 = write
o_Mem_En  output  1  memory access strobe
i_Mem_Dato  input  DATA_W  memory read data
o_Ocupado  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, i_Clk. Reset i_Rst_n is asynchronous and active-low.
- Reset values: all outputs 0 except o_Mem_RW = 1. Last-grant flag resets to "data", so fetch wins the first tie.
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE: o_Mem_En = 0 and o_Mem_RW = 1; address and data outputs hold their last values.
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the requester not granted last.
  - On grant: latch address, write data and RW (fetch always reads), then go to SETUP.
- SETUP (1 cycle): drive latched o_Mem_Dir, o_Mem_Dato and o_Mem_RW; o_Mem_En = 0. Go to ACCESS and load the counter with WAIT_CYC-1.
- ACCESS: o_Mem_En = 1, counter decrements each cycle.
  - At counter 0 on a read, register i_Mem_Dato into o_Dato_Leido and go to DONE.
  - On a write, o_Dato_Leido is unchanged.
- DONE (1 cycle): o_Mem_En = 0. Assert the granted requester's ack, update the last-grant flag, go to IDLE.
- Bus stability: o_Mem_Dir, o_Mem_Dato and o_Mem_RW stay stable from SETUP through DONE. Requester input changes after grant are ignored.
- Latency: with the request sampled in IDLE at cycle 0, ack is high in cycle WAIT_CYC+2. Back-to-back throughput is one transaction per WAIT_CYC+3 cycles.
- Handshake rule: a requester drops its request on the edge where it samples ack = 1. A request still high in the following IDLE cycle is a new transaction.
- Acks: never both high in the same cycle. Never asserted outside DONE.
- Request drop before ack: protocol violation. The transaction completes and acks anyway.
- Reset mid-operation: immediate return to reset values and IDLE. The in-flight transaction is aborted with no ack and no o_Dato_Leido update. Requests still high after release are re-arbitrated from IDLE, fetch first.

Test Plan:
1. WAIT_CYC=2, fetch 0x3A, i_Mem_Dato=0x5C:
   - o_Mem_Dir=0x3A and o_Mem_RW=1 from cycle 1.
   - o_Mem_En high in cycles 2–3.
   - o_Fetch_Ack in cycle 4; o_Dato_Leido=0x5C.
   - o_Ocupado high in cycles 1–4.
2. Data write, address 0xAA, data 0x55:
   - o_Mem_RW=0, o_Mem_Dir=0xAA, o_Mem_Dato=0x55 held in cycles 1–4.
   - o_Dato_Ack in cycle 4; o_Dato_Leido unchanged; o_Fetch_Ack stays 0.
3. After reset, both requests held continuously with fetch 0x10 and data read 0x20:
   - Grants alternate fetch, data, fetch, data.
   - Acks in cycles 4, 9, 14, 19.
   - o_Mem_Dir alternates 0x10 / 0x20.
4. During a fetch to 0x3A, i_Fetch_Dir changes to 0xFF in cycle 2 → o_Mem_Dir stays 0x3A through cycle 4.
5. i_Rst_n low in cycle 2 of a data read, while its request stays high:
   - Outputs at reset values immediately; no ack; o_Dato_Leido = 0.
   - After release, the transaction restarts and acks WAIT_CYC+2 cycles after its IDLE sample.
6. WAIT_CYC=4, fetch read → o_Mem_En high in cycles 2–5, o_Fetch_Ack in cycle 6.
